// File: rtl/inst_cache_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache_refill_pkg
// Description : Shared constants for the instruction-cache line-fill path.
//               Holds the cache geometry (index/offset/bank layout), the
//               refill FSM state encoding and the AXI4 field constants used
//               when requesting a line.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_cache_refill_pkg;

    // ------------------------------------------------------------------
    // Cache geometry
    // ------------------------------------------------------------------
    localparam int INST_CACHE_INDEX_WIDTH  = 7;   // 128 lines
    localparam int INST_CACHE_OFFSET_WIDTH = 5;   // 32-byte lines
    localparam int INST_CACHE_BANK_WIDTH   = 32;  // one word per bank
    localparam int INST_CACHE_BANK_NUM     = 8;   // words per line
    localparam int INST_CACHE_LINE_WIDTH   = INST_CACHE_BANK_WIDTH * INST_CACHE_BANK_NUM;
    localparam int INST_CACHE_CNT_WIDTH    = $clog2(INST_CACHE_BANK_NUM);

    // ------------------------------------------------------------------
    // Refill FSM state encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_WRITE = 2'd3
    } refill_state_e;

    // ------------------------------------------------------------------
    // AXI4 constants
    // ------------------------------------------------------------------
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [2:0] SIZE_4B      = 3'd2;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    // AXI length is beats-1
    localparam logic [7:0] AXI_LEN_LINE = 8'(INST_CACHE_BANK_NUM - 1);

    // Line-aligned form of a byte address; the burst always starts at the
    // first word of the line regardless of which word missed.
    function automatic logic [31:0] line_aligned(input logic [31:0] addr);
        return {addr[31:INST_CACHE_OFFSET_WIDTH], {INST_CACHE_OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_cache_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache_line_buffer
// Description : 8 x 32-bit register file that assembles one cache line from
//               incoming burst beats. One indexed write port, one indexed
//               word read port, and a full packed 256-bit line view in the
//               data-RAM bank order (word 0 in the most significant bits).
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (clears all words)
//               wr_en    - write strobe
//               wr_idx   - word slot to write
//               wr_data  - word to write
//               rd_idx   - word slot to read
//               rd_data  - word at rd_idx
//               line     - packed line, word k at [255-32k -: 32]
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cache_line_buffer
    import inst_cache_refill_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [INST_CACHE_CNT_WIDTH-1:0]   wr_idx,
    input  logic [INST_CACHE_BANK_WIDTH-1:0]  wr_data,
    input  logic [INST_CACHE_CNT_WIDTH-1:0]   rd_idx,
    output logic [INST_CACHE_BANK_WIDTH-1:0]  rd_data,
    output logic [INST_CACHE_LINE_WIDTH-1:0]  line
);

    logic [INST_CACHE_BANK_WIDTH-1:0] r_words [INST_CACHE_BANK_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INST_CACHE_BANK_NUM; i++) begin
                r_words[i] <= '0;
            end
        end else if (wr_en) begin
            r_words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_words[rd_idx];

    // Same bank packing the read path decodes: beat 0 lands in the top word.
    generate
        for (genvar k = 0; k < INST_CACHE_BANK_NUM; k++) begin : g_pack
            assign line[INST_CACHE_LINE_WIDTH-1-INST_CACHE_BANK_WIDTH*k -: INST_CACHE_BANK_WIDTH] = r_words[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/inst_cache_refill.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache_refill
// Description : Instruction-cache line-fill engine. On a miss it issues one
//               AXI4 INCR read burst of 8 x 32-bit beats for the 32-byte
//               line, assembles the beats in a line buffer and writes the
//               whole 256-bit line into the data RAM in a single cycle. The
//               missed word is returned to fetch in that same cycle.
//               Any error (bad response, wrong burst length) suppresses the
//               RAM write and is reported through fill_err.
// Ports       : clk, rst                 - clock, sync active-high reset
//               req_valid/req_ready      - miss request handshake
//               req_addr                 - missed physical address
//               ar*                      - AXI4 read address channel
//               r*                       - AXI4 read data channel
//               ram_en/ram_wen           - data-RAM enable / byte enables
//               ram_index/ram_wdata      - data-RAM line index / line data
//               fill_done                - one-cycle completion pulse
//               fill_err                 - fill failed, line not written
//               fill_word                - word at req_addr[4:2]
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cache_refill
    import inst_cache_refill_pkg::*;
#(
    parameter int         INDEX_WIDTH  = INST_CACHE_INDEX_WIDTH,
    parameter int         OFFSET_WIDTH = INST_CACHE_OFFSET_WIDTH,
    parameter int         BEAT_NUM     = INST_CACHE_BANK_NUM,
    parameter logic [3:0] AXI_ID       = 4'd0
) (
    input  logic                             clk,
    input  logic                             rst,

    // Miss request
    input  logic                             req_valid,
    input  logic [31:0]                      req_addr,
    output logic                             req_ready,

    // AXI4 read address channel
    output logic [3:0]                       arid,
    output logic [31:0]                      araddr,
    output logic [7:0]                       arlen,
    output logic [2:0]                       arsize,
    output logic [1:0]                       arburst,
    output logic                             arvalid,
    input  logic                             arready,

    // AXI4 read data channel
    input  logic [3:0]                       rid,
    input  logic [31:0]                      rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rlast,
    input  logic                             rvalid,
    output logic                             rready,

    // Data RAM write port
    output logic                             ram_en,
    output logic [31:0]                      ram_wen,
    output logic [INDEX_WIDTH-1:0]           ram_index,
    output logic [INST_CACHE_LINE_WIDTH-1:0] ram_wdata,

    // Fetch-side completion
    output logic                             fill_done,
    output logic                             fill_err,
    output logic [31:0]                      fill_word
);

    localparam logic [INST_CACHE_CNT_WIDTH-1:0] c_last_beat = INST_CACHE_CNT_WIDTH'(BEAT_NUM - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    refill_state_e                     r_state;
    logic [31:0]                       r_addr;
    logic [INST_CACHE_CNT_WIDTH-1:0]   r_cnt;
    logic                              r_err;
    logic                              r_req_ready;
    logic                              r_arvalid;
    logic                              r_rready;
    logic                              r_ram_en;
    logic                              r_fill_done;
    logic                              r_fill_err;

    logic                              w_beat;
    logic                              w_err_next;
    logic [INST_CACHE_LINE_WIDTH-1:0]  w_line;
    logic [INST_CACHE_BANK_WIDTH-1:0]  w_req_word;

    // An accepted R beat; rready is only ever high in ST_R.
    assign w_beat = rvalid && r_rready;

    // Sticky error including the beat currently being accepted:
    // - any non-OKAY response
    // - rlast on a beat other than the 8th
    // - an 8th beat without rlast (counter wraps; keep waiting for rlast)
    always_comb begin
        w_err_next = r_err;
        if (rresp != RESP_OKAY) begin
            w_err_next = 1'b1;
        end
        if (rlast != (r_cnt == c_last_beat)) begin
            w_err_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Refill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_ram_en    <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_err  <= 1'b0;
        end else begin
            // Completion strobes are single-cycle.
            r_ram_en    <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_arvalid   <= 1'b1;
                        r_state     <= ST_AR;
                    end
                end

                ST_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end

                ST_R: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_err <= w_err_next;
                        if (rlast) begin
                            r_rready    <= 1'b0;
                            r_fill_done <= 1'b1;
                            r_fill_err  <= w_err_next;
                            r_ram_en    <= !w_err_next;
                            r_state     <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line buffer
    // ------------------------------------------------------------------
    inst_cache_line_buffer u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_beat),
        .wr_idx  (r_cnt),
        .wr_data (rdata),
        .rd_idx  (r_addr[OFFSET_WIDTH-1:2]),
        .rd_data (w_req_word),
        .line    (w_line)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = r_req_ready;

    // AR fields derive from the latched address, so they stay stable for
    // the whole AR phase without extra holding logic.
    assign arid    = AXI_ID;
    assign araddr  = line_aligned(r_addr);
    assign arlen   = AXI_LEN_LINE;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    // RAM port is quiet except on a successful WRITE cycle. By the time
    // r_ram_en is set the last beat is already in the buffer.
    assign ram_en    = r_ram_en;
    assign ram_wen   = r_ram_en ? 32'hFFFF_FFFF : 32'h0000_0000;
    assign ram_index = r_ram_en ? r_addr[OFFSET_WIDTH +: INDEX_WIDTH] : '0;
    assign ram_wdata = r_ram_en ? w_line : '0;

    assign fill_done = r_fill_done;
    assign fill_err  = r_fill_err;
    assign fill_word = w_req_word;

    // rid carries no information for a single-outstanding engine, and the
    // byte offset within a word is irrelevant to a word-granular fill.
    logic w_unused;
    assign w_unused = &{1'b0, rid, r_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_inst_cache_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_cache_refill
// Description : Self-checking bench for inst_cache_refill. A driver plays the
//               miss requester and the AXI slave, pushing the expected fill
//               result into a scoreboard queue when each request is issued.
//               A monitor pops and compares on every fill_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_cache_refill;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         req_ready;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [3:0]   rid = '0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic         ram_en;
    logic [31:0]  ram_wen;
    logic [6:0]   ram_index;
    logic [255:0] ram_wdata;
    logic         fill_done;
    logic         fill_err;
    logic [31:0]  fill_word;

    inst_cache_refill dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_index (ram_index),
        .ram_wdata (ram_wdata),
        .fill_done (fill_done),
        .fill_err  (fill_err),
        .fill_word (fill_word)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Expected outcome of one fill
    typedef struct {
        logic         err;
        logic [6:0]   idx;
        logic [255:0] line;
        logic [31:0]  word;
    } exp_t;

    exp_t sb_q[$];

    // AR handshakes seen at the clock edge
    int ar_hs = 0;
    always @(posedge clk) begin
        if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;
    end

    // ------------------------------------------------------------------
    // Monitor: compares every fill against the scoreboard and checks the
    // RAM port is quiet at all other times.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fill_done) begin
                    if (sb_q.size() == 0) begin
                        timeout("unexpected_fill_done");
                    end else begin
                        e = sb_q.pop_front();
                        check("fill_err", fill_err, e.err);
                        check("ram_en", ram_en, !e.err);
                        check("ram_wen", ram_wen, e.err ? 32'h0 : 32'hFFFF_FFFF);
                        if (!e.err) begin
                            check("ram_index", ram_index, e.idx);
                            check("ram_wdata", ram_wdata, e.line);
                            check("fill_word", fill_word, e.word);
                        end
                    end
                end else begin
                    check("ram_quiet", {fill_err, ram_en, ram_wen, ram_index, ram_wdata != 256'd0}, '0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: one miss request plus AXI slave behaviour.
    //   gap_mode 0: beats back-to-back, 1: every other cycle, 2: random
    //   err_beat : beat index answered with SLVERR (-1 none)
    //   nbeats   : beats sent, rlast on the final one
    //   abort_after: pulse rst after this beat index is accepted (-1 none)
    // ------------------------------------------------------------------
    task automatic run_fill(input logic [31:0] addr, input int ar_delay, input int gap_mode,
                            input int err_beat, input int nbeats, input bit hold_req,
                            input int abort_after, input bit chk_latency, input bit seq_data);
        logic [31:0]  data[$];
        logic [255:0] line;
        exp_t         e;
        int           acc_cyc, ar0, wait_n, b;
        bit           err;

        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready) begin
            timeout("req_ready");
            return;
        end

        for (int k = 0; k < nbeats; k++) begin
            data.push_back(seq_data ? (32'hA0 + 32'(k)) : $urandom);
        end
        err  = (nbeats != 8) || (err_beat >= 0 && err_beat < nbeats);
        line = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < nbeats) line[255-32*k -: 32] = data[k];
        end
        e.err  = err;
        e.idx  = addr[11:5];
        e.line = line;
        e.word = (int'(addr[4:2]) < nbeats) ? data[addr[4:2]] : 32'h0;
        if (abort_after < 0) sb_q.push_back(e);

        req_valid = 1'b1;
        req_addr  = addr;
        acc_cyc   = cyc;
        ar0       = ar_hs;
        @(negedge clk);
        if (!hold_req) begin
            req_valid = 1'b0;
            req_addr  = $urandom;
        end

        // AR phase
        wait_n = 0;
        while (!arvalid && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!arvalid) begin
            timeout("arvalid");
            return;
        end
        for (int d = 0; d <= ar_delay; d++) begin
            check("araddr", araddr, {addr[31:5], 5'b0});
            check("ar_ctl", {arvalid, arid, arlen, arsize, arburst}, {1'b1, 4'd0, 8'd7, 3'd2, 2'b01});
            if (d == ar_delay) arready = 1'b1;
            @(negedge clk);
        end
        arready = 1'b0;

        // R phase
        b      = 0;
        wait_n = 0;
        while (b < nbeats && wait_n < 200) begin
            if (abort_after >= 0 && b > abort_after) break;
            wait_n++;
            if ((gap_mode == 1 && (wait_n % 2 == 0)) ||
                (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                rvalid = 1'b0;
            end else begin
                rvalid = 1'b1;
                rdata  = data[b];
                rresp  = (b == err_beat) ? 2'b10 : 2'b00;
                rlast  = (b == nbeats - 1);
                rid    = 4'($urandom);
                if (rready) b++;
            end
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;

        if (abort_after >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_state", {req_ready, arvalid, rready, ram_en, fill_done}, 5'b10000);
            @(negedge clk);
            return;
        end
        if (b < nbeats) begin
            timeout("r_beats");
            return;
        end

        wait_n = 0;
        while (!fill_done && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!fill_done) begin
            timeout("fill_done");
            return;
        end
        if (chk_latency) check("latency", 256'(cyc - acc_cyc), 256'd10);
        check("single_ar", 256'(ar_hs - ar0), 256'd1);
        check("no_ar_in_write", arvalid, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        check("back_to_idle", req_ready, 1'b1);
    endtask

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb;
        repeat (3) @(negedge clk);
        check("rst_ctl", {req_ready, arvalid, rready, ram_en, fill_done, fill_err}, 6'b100000);
        check("rst_ram", {ram_wen, ram_wdata}, '0);
        check("rst_fill_word", fill_word, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Clean fill, sequential beats A0..A7
        run_fill(32'h1FC0_0014, 0, 0, -1, 8, 1'b0, -1, 1'b1, 1'b1);
        // Backpressure on AR and gaps on R
        run_fill(32'h2000_1048, 3, 1, -1, 8, 1'b0, -1, 1'b0, 1'b0);
        // SLVERR on beat 3
        run_fill(32'h0000_2260, 0, 0, 3, 8, 1'b0, -1, 1'b0, 1'b0);
        // Early rlast on beat 5
        run_fill(32'h0000_3380, 1, 0, -1, 6, 1'b0, -1, 1'b0, 1'b0);
        // Reset after beat 4, then a fill of the last index
        run_fill(32'h8000_44A4, 0, 0, -1, 8, 1'b0, 4, 1'b0, 1'b0);
        run_fill(32'h0000_0FE0, 0, 0, -1, 8, 1'b0, -1, 1'b1, 1'b0);
        // Request held high throughout
        run_fill(32'h1234_567C, 0, 2, -1, 8, 1'b1, -1, 1'b0, 1'b0);
        // Burst too long: counter wraps, still waits for rlast
        run_fill(32'h0000_5500, 0, 0, -1, 10, 1'b0, -1, 1'b0, 1'b0);

        // Random fills
        for (int i = 0; i < 24; i++) begin
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_fill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), eb, 8,
                     1'b0, -1, 1'b0, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 256'(sb_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
